// File: rtl/move_dispatch.sv
// move_dispatch: accepts one move request, snapshots the board, runs legality
// prechecks, starts the matching per-piece checker and returns one verdict.
module move_dispatch #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [3:0] EMPTY_CODE     = 4'd15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           old_x,
    input  logic [2:0]           old_y,
    input  logic [2:0]           new_x,
    input  logic [2:0]           new_y,
    input  logic                 player,
    input  logic [7:0][7:0][3:0] board_in,
    output logic [2:0]           chk_old_x,
    output logic [2:0]           chk_old_y,
    output logic [2:0]           chk_new_x,
    output logic [2:0]           chk_new_y,
    output logic [2:0]           chk_h_delta,
    output logic [2:0]           chk_v_delta,
    output logic                 chk_fwd,
    output logic [3:0]           chk_piece_type,
    output logic [7:0][7:0][3:0] chk_board,
    output logic [5:0]           chk_valid_input,
    input  logic [5:0]           chk_valid_move,
    input  logic [5:0]           chk_valid_output,
    output logic                 rsp_valid,
    output logic                 rsp_legal,
    output logic [1:0]           rsp_err
);
    localparam int            CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PRECHECK, DISPATCH, WAIT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             oldX_q, oldY_q, newX_q, newY_q;
    logic [2:0]             hDelta_q, vDelta_q;
    logic                   fwd_q, player_q;
    logic [3:0]             pieceType_q;
    logic [7:0][7:0][3:0]   board_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   verdictLegal_q, verdictLegal_d;
    logic [1:0]             verdictErr_q, verdictErr_d;
    logic [5:0]             validIn_q;
    logic                   rspValid_q, rspLegal_q;
    logic [1:0]             rspErr_q;

    logic                   accept;
    logic [2:0]             idx;
    logic [3:0]             dstCode;
    logic [7:0]             doneVec, moveVec, oneHot;

    // Codes 6, 7 and 14 carry no piece, same as the dedicated empty code.
    function automatic logic isEmpty(input logic [3:0] code);
        return (code == EMPTY_CODE) || (code[2:1] == 2'b11);
    endfunction

    function automatic logic [2:0] absDiff(input logic [2:0] a, input logic [2:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && (state_q == IDLE);
    assign idx       = pieceType_q[2:0];
    assign dstCode   = board_q[newY_q][newX_q];
    assign doneVec   = {2'b00, chk_valid_output};
    assign moveVec   = {2'b00, chk_valid_move};
    assign oneHot    = 8'd1 << idx;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        verdictLegal_d = verdictLegal_q;
        verdictErr_d   = verdictErr_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) state_d = PRECHECK;
            end
            PRECHECK: begin
                if (isEmpty(pieceType_q) || (pieceType_q[3] != player_q)) begin
                    verdictLegal_d = 1'b0;
                    verdictErr_d   = 2'd1;
                    state_d        = DONE;
                end else if ((oldX_q == newX_q) && (oldY_q == newY_q)) begin
                    verdictLegal_d = 1'b0;
                    verdictErr_d   = 2'd2;
                    state_d        = DONE;
                end else if (!isEmpty(dstCode) && (dstCode[3] == player_q)) begin
                    verdictLegal_d = 1'b0;
                    verdictErr_d   = 2'd2;
                    state_d        = DONE;
                end else begin
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving in the last allowed cycle still wins over the timeout.
                if (doneVec[idx]) begin
                    verdictLegal_d = moveVec[idx];
                    verdictErr_d   = 2'd0;
                    state_d        = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    verdictLegal_d = 1'b0;
                    verdictErr_d   = 2'd3;
                    state_d        = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            verdictLegal_q <= 1'b0;
            verdictErr_q   <= 2'd0;
            oldX_q         <= '0;
            oldY_q         <= '0;
            newX_q         <= '0;
            newY_q         <= '0;
            hDelta_q       <= '0;
            vDelta_q       <= '0;
            fwd_q          <= 1'b0;
            player_q       <= 1'b0;
            pieceType_q    <= EMPTY_CODE;
            board_q        <= '0;
            validIn_q      <= '0;
            rspValid_q     <= 1'b0;
            rspLegal_q     <= 1'b0;
            rspErr_q       <= 2'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            verdictLegal_q <= verdictLegal_d;
            verdictErr_q   <= verdictErr_d;
            if (accept) begin
                oldX_q      <= old_x;
                oldY_q      <= old_y;
                newX_q      <= new_x;
                newY_q      <= new_y;
                hDelta_q    <= absDiff(new_x, old_x);
                vDelta_q    <= absDiff(new_y, old_y);
                fwd_q       <= (new_y < old_y);
                player_q    <= player;
                pieceType_q <= board_in[old_y][old_x];
                board_q     <= board_in;
            end
            validIn_q  <= (state_d == DISPATCH) ? oneHot[5:0] : 6'd0;
            // The verdict is published one cycle after DONE so it leaves from flops only.
            rspValid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                rspLegal_q <= verdictLegal_q;
                rspErr_q   <= verdictErr_q;
            end
        end
    end

    assign chk_old_x       = oldX_q;
    assign chk_old_y       = oldY_q;
    assign chk_new_x       = newX_q;
    assign chk_new_y       = newY_q;
    assign chk_h_delta     = hDelta_q;
    assign chk_v_delta     = vDelta_q;
    assign chk_fwd         = fwd_q;
    assign chk_piece_type  = pieceType_q;
    assign chk_board       = board_q;
    assign chk_valid_input = validIn_q;
    assign rsp_valid       = rspValid_q;
    assign rsp_legal       = rspLegal_q;
    assign rsp_err         = rspErr_q;
endmodule

// File: tb/tb_move_dispatch.sv
// Testbench for move_dispatch: hand-written vector table plus randomized moves
// checked against a rule-level reference model, with a reactive checker model.
module tb_move_dispatch;
    localparam int         TIMEOUT = 8;
    localparam logic [3:0] EMPTY   = 4'd15;

    logic                 clk, reset_n, req_valid, req_ready, player;
    logic [2:0]           old_x, old_y, new_x, new_y;
    logic [7:0][7:0][3:0] board_in, chk_board;
    logic [2:0]           chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta;
    logic                 chk_fwd;
    logic [3:0]           chk_piece_type;
    logic [5:0]           chk_valid_input, chk_valid_move, chk_valid_output;
    logic                 rsp_valid, rsp_legal;
    logic [1:0]           rsp_err;

    logic [7:0][7:0][3:0] board;
    int checks;
    int failures;

    typedef struct {
        logic [2:0] ox, oy, nx, ny;
        logic       pl;
        logic [3:0] src, dst;
        int         delay;
        logic       move;
        logic       noise;
        int         err;
        logic       legal;
        logic [5:0] oneHot;
        int         h, v;
        logic       fwd;
    } vec_t;

    vec_t vecs[15];

    move_dispatch #(.TIMEOUT_CYCLES(TIMEOUT), .EMPTY_CODE(EMPTY)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
        .player(player), .board_in(board_in),
        .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
        .chk_new_x(chk_new_x), .chk_new_y(chk_new_y),
        .chk_h_delta(chk_h_delta), .chk_v_delta(chk_v_delta), .chk_fwd(chk_fwd),
        .chk_piece_type(chk_piece_type), .chk_board(chk_board),
        .chk_valid_input(chk_valid_input), .chk_valid_move(chk_valid_move),
        .chk_valid_output(chk_valid_output),
        .rsp_valid(rsp_valid), .rsp_legal(rsp_legal), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " req_ready"}, 64'(req_ready), 64'd1);
        checkOutput({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, " rsp_legal"}, 64'(rsp_legal), 64'd0);
        checkOutput({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
        checkOutput({tag, " chk_valid_input"}, 64'(chk_valid_input), 64'd0);
        checkOutput({tag, " chk_piece_type"}, 64'(chk_piece_type), 64'(EMPTY));
        checkOutput({tag, " coords/deltas"},
                    64'({chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta, chk_fwd}), 64'd0);
        checkOutput({tag, " chk_board zero"}, 64'(chk_board === '0), 64'd1);
    endtask

    // Rule-level legality precheck: 0 means the move goes to a checker.
    function automatic int refPrecheck(input logic [7:0][7:0][3:0] brd, input int ox, input int oy,
                                       input int nx, input int ny, input int pl);
        int src;
        int dst;
        bit srcEmpty;
        bit dstEmpty;
        src = int'(brd[oy][ox]);
        dst = int'(brd[ny][nx]);
        srcEmpty = (src == int'(EMPTY)) || (src inside {6, 7, 14});
        dstEmpty = (dst == int'(EMPTY)) || (dst inside {6, 7, 14});
        if (srcEmpty || (src / 8) != pl) return 1;
        if (ox == nx && oy == ny) return 2;
        if (!dstEmpty && (dst / 8) == pl) return 2;
        return 0;
    endfunction

    function automatic int absInt(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic applyStimulus(input string name, input logic [2:0] ox, input logic [2:0] oy,
                                 input logic [2:0] nx, input logic [2:0] ny, input logic pl,
                                 input int respDelay, input logic respMove, input logic noise,
                                 input int expErr, input logic expLegal, input logic [5:0] expOneHot,
                                 input int expH, input int expV, input logic expFwd);
        int lat, rspK, dispK, pulses;
        logic [5:0] seenOneHot;
        logic rspLegalSeen, stableOk, readyOk;
        logic [1:0] rspErrSeen;
        logic [3:0] expPiece;
        if (expErr == 1 || expErr == 2) lat = 2;
        else if (expErr == 3) lat = 3 + TIMEOUT;
        else lat = 4 + respDelay;
        expPiece = board[oy][ox];
        old_x = ox; old_y = oy; new_x = nx; new_y = ny; player = pl;
        board_in = board; req_valid = 1'b1;
        @(posedge clk); #1;
        rspK = -1; dispK = -1; pulses = 0; seenOneHot = '0;
        rspLegalSeen = 1'b0; rspErrSeen = 2'd0; stableOk = 1'b1; readyOk = 1'b1;
        for (int k = 0; k <= lat + 1; k++) begin
            req_valid = (k < lat);
            if (noise) begin
                old_x = 3'($urandom); old_y = 3'($urandom);
                new_x = 3'($urandom); new_y = 3'($urandom); player = 1'($urandom);
                for (int y = 0; y < 8; y++)
                    for (int x = 0; x < 8; x++)
                        board_in[y][x] = 4'($urandom);
            end
            chk_valid_output = noise ? (6'($urandom) & ~expOneHot) : 6'd0;
            chk_valid_move   = 6'($urandom);
            if (respDelay >= 0 && dispK >= 0 && k == dispK + 1 + respDelay) begin
                chk_valid_output = chk_valid_output | seenOneHot;
                chk_valid_move   = respMove ? (chk_valid_move | seenOneHot) : (chk_valid_move & ~seenOneHot);
            end
            @(negedge clk);
            if (chk_valid_input != 6'd0) begin
                pulses++;
                seenOneHot = chk_valid_input;
                if (dispK < 0) dispK = k;
            end
            if (rsp_valid) begin
                if (rspK == -1) begin
                    rspK = k;
                    rspLegalSeen = rsp_legal;
                    rspErrSeen = rsp_err;
                end else begin
                    rspK = -2;
                end
            end
            if (req_ready !== (k >= lat)) readyOk = 1'b0;
            if (chk_old_x !== ox || chk_old_y !== oy || chk_new_x !== nx || chk_new_y !== ny ||
                chk_h_delta !== 3'(expH) || chk_v_delta !== 3'(expV) || chk_fwd !== expFwd ||
                chk_piece_type !== expPiece || chk_board !== board)
                stableOk = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; chk_valid_output = '0; chk_valid_move = '0;
        checkOutput({name, " rsp_valid cycle"}, 64'(rspK), 64'(lat));
        checkOutput({name, " rsp_legal"}, 64'(rspLegalSeen), 64'(expLegal));
        checkOutput({name, " rsp_err"}, 64'(rspErrSeen), 64'(expErr));
        checkOutput({name, " start pulses"}, 64'(pulses), (expOneHot != 6'd0) ? 64'd1 : 64'd0);
        checkOutput({name, " start one-hot"}, 64'(seenOneHot), 64'(expOneHot));
        checkOutput({name, " chk outputs stable"}, 64'(stableOk), 64'd1);
        checkOutput({name, " req_ready timing"}, 64'(readyOk), 64'd1);
        checkOutput({name, " verdict hold"}, 64'({rsp_legal, rsp_err}), 64'({expLegal, 2'(expErr)}));
    endtask

    initial begin
        int rspCount;
        checks = 0; failures = 0;
        reset_n = 1'b0; req_valid = 1'b0; player = 1'b0;
        old_x = '0; old_y = '0; new_x = '0; new_y = '0;
        board_in = '0; chk_valid_move = '0; chk_valid_output = '0;

        vecs[0]  = '{3'd4, 3'd6, 3'd4, 3'd5, 1'b0, 4'd0,  4'd15, 0,  1'b1, 1'b0, 0, 1'b1, 6'b000001, 0, 1, 1'b1};
        vecs[1]  = '{3'd2, 3'd2, 3'd2, 3'd1, 1'b0, 4'd15, 4'd15, 0,  1'b0, 1'b0, 1, 1'b0, 6'b000000, 0, 1, 1'b1};
        vecs[2]  = '{3'd0, 3'd7, 3'd0, 3'd6, 1'b0, 4'd3,  4'd0,  0,  1'b0, 1'b1, 2, 1'b0, 6'b000000, 0, 1, 1'b1};
        vecs[3]  = '{3'd3, 3'd3, 3'd3, 3'd3, 1'b0, 4'd3,  4'd3,  0,  1'b0, 1'b0, 2, 1'b0, 6'b000000, 0, 0, 1'b0};
        vecs[4]  = '{3'd1, 3'd7, 3'd2, 3'd5, 1'b0, 4'd1,  4'd15, -1, 1'b0, 1'b1, 3, 1'b0, 6'b000010, 1, 2, 1'b1};
        vecs[5]  = '{3'd7, 3'd0, 3'd0, 3'd7, 1'b1, 4'd12, 4'd15, 0,  1'b0, 1'b0, 0, 1'b0, 6'b010000, 7, 7, 1'b0};
        vecs[6]  = '{3'd5, 3'd5, 3'd5, 3'd4, 1'b0, 4'd6,  4'd15, 0,  1'b1, 1'b0, 1, 1'b0, 6'b000000, 0, 1, 1'b1};
        vecs[7]  = '{3'd2, 3'd6, 3'd2, 3'd4, 1'b1, 4'd14, 4'd15, 0,  1'b1, 1'b1, 1, 1'b0, 6'b000000, 0, 2, 1'b1};
        vecs[8]  = '{3'd4, 3'd4, 3'd6, 3'd2, 1'b0, 4'd10, 4'd15, 0,  1'b1, 1'b0, 1, 1'b0, 6'b000000, 2, 2, 1'b1};
        vecs[9]  = '{3'd4, 3'd7, 3'd4, 3'd6, 1'b0, 4'd5,  4'd8,  3,  1'b1, 1'b1, 0, 1'b1, 6'b100000, 0, 1, 1'b1};
        vecs[10] = '{3'd6, 3'd0, 3'd5, 3'd2, 1'b1, 4'd9,  4'd7,  7,  1'b1, 1'b1, 0, 1'b1, 6'b000010, 1, 2, 1'b0};
        vecs[11] = '{3'd0, 3'd0, 3'd7, 3'd7, 1'b0, 4'd2,  4'd15, 2,  1'b1, 1'b0, 0, 1'b1, 6'b000100, 7, 7, 1'b0};
        vecs[12] = '{3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 4'd11, 4'd8,  0,  1'b1, 1'b0, 2, 1'b0, 6'b000000, 0, 1, 1'b1};
        vecs[13] = '{3'd3, 3'd1, 3'd3, 3'd0, 1'b1, 4'd8,  4'd15, 1,  1'b0, 1'b1, 0, 1'b0, 6'b000001, 0, 1, 1'b1};
        vecs[14] = '{3'd1, 3'd1, 3'd1, 3'd5, 1'b0, 4'd3,  4'd13, 5,  1'b1, 1'b1, 0, 1'b1, 6'b001000, 0, 4, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    board[y][x] = EMPTY;
            board[vecs[i].oy][vecs[i].ox] = vecs[i].src;
            board[vecs[i].ny][vecs[i].nx] = vecs[i].dst;
            applyStimulus($sformatf("vec%0d", i), vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny,
                          vecs[i].pl, vecs[i].delay, vecs[i].move, vecs[i].noise, vecs[i].err,
                          vecs[i].legal, vecs[i].oneHot, vecs[i].h, vecs[i].v, vecs[i].fwd);
        end

        // Reset in the middle of a checker wait must abort silently.
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                board[y][x] = EMPTY;
        board[7][1] = 4'd1;
        old_x = 3'd1; old_y = 3'd7; new_x = 3'd2; new_y = 3'd5; player = 1'b0;
        board_in = board; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkResetValues("midreset");
        rspCount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) rspCount++;
            if (k == 2) reset_n = 1'b1;
        end
        checkOutput("midreset rsp_valid pulses", 64'(rspCount), 64'd0);
        @(posedge clk); #1;
        board[7][1] = EMPTY;
        board[6][4] = 4'd0;
        applyStimulus("after reset", 3'd4, 3'd6, 3'd4, 3'd5, 1'b0, 0, 1'b1, 1'b0,
                      0, 1'b1, 6'b000001, 0, 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] ox, oy, nx, ny;
            logic pl, mv;
            int d, pre, err;
            logic [5:0] oh;
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    board[y][x] = 4'($urandom_range(0, 15));
            ox = 3'($urandom); oy = 3'($urandom); nx = 3'($urandom); ny = 3'($urandom);
            pl = 1'($urandom);
            if ($urandom_range(0, 9) < 7) board[oy][ox] = {pl, 3'($urandom_range(0, 5))};
            if ($urandom_range(0, 4) == 0) begin
                nx = ox; ny = oy;
            end
            d  = $urandom_range(0, 10);
            mv = 1'($urandom);
            pre = refPrecheck(board, int'(ox), int'(oy), int'(nx), int'(ny), int'(pl));
            if (pre != 0) err = pre;
            else if (d >= TIMEOUT) err = 3;
            else err = 0;
            oh = (pre == 0) ? 6'(1 << (int'(board[oy][ox]) % 8)) : 6'd0;
            applyStimulus($sformatf("rand%0d", i), ox, oy, nx, ny, pl, d, mv, 1'($urandom),
                          err, (err == 0) ? mv : 1'b0, oh,
                          absInt(int'(nx) - int'(ox)), absInt(int'(ny) - int'(oy)), (ny < oy));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
